// File: rtl/led_cnt_multi.sv
// Multi-channel LED controller: per-channel off/on/blink/one-shot driven by a shared tick prescaler.
// Optional build macro LED_CNT_MULTI_SYNC_EN adds sync_i to realign the prescaler and all blink channels.
module led_cnt_multi #(
    parameter int NUM_CH   = 4,
    parameter int DIV_W    = 12,
    parameter int PRESCALE = 100000
) (
    input  logic                      clk100,
    input  logic                      rst,
`ifdef LED_CNT_MULTI_SYNC_EN
    input  logic                      sync_i,
`endif
    input  logic [DIV_W-1:0]          div_i,
    input  logic [1:0]                mode_i,
    input  logic [$clog2(NUM_CH)-1:0] ch_i,
    input  logic                      wren_i,
    output logic [NUM_CH-1:0]         led_o,
    output logic [NUM_CH-1:0]         led_int_o
);

    localparam int CH_W = $clog2(NUM_CH);
    localparam int PW   = $clog2(PRESCALE);
    localparam logic [PW-1:0] PRE_LAST = PW'(PRESCALE - 1);

    localparam logic [1:0] MODE_OFF     = 2'b00;
    localparam logic [1:0] MODE_BLINK   = 2'b10;
    localparam logic [1:0] MODE_ONESHOT = 2'b11;

    logic [PW-1:0]    pre_q, pre_d;
    logic             tick;
    logic             sync;

    logic [DIV_W-1:0] div_q  [NUM_CH];
    logic [DIV_W-1:0] div_d  [NUM_CH];
    logic [DIV_W-1:0] cnt_q  [NUM_CH];
    logic [DIV_W-1:0] cnt_d  [NUM_CH];
    logic [1:0]       mode_q [NUM_CH];
    logic [1:0]       mode_d [NUM_CH];
    logic [NUM_CH-1:0] led_q, led_d;
    logic [NUM_CH-1:0] int_q, int_d;

`ifdef LED_CNT_MULTI_SYNC_EN
    assign sync = sync_i;
`else
    assign sync = 1'b0;
`endif

    always_comb begin
        tick  = (pre_q == PRE_LAST);
        pre_d = (sync || tick) ? '0 : pre_q + PW'(1);
    end

    // Priority per channel: write, then sync (blink only), then tick.
    always_comb begin
        for (int c = 0; c < NUM_CH; c++) begin
            div_d[c]  = div_q[c];
            cnt_d[c]  = cnt_q[c];
            mode_d[c] = mode_q[c];
            led_d[c]  = led_q[c];
            int_d[c]  = 1'b0;
            if (wren_i && (ch_i == CH_W'(c))) begin
                div_d[c]  = div_i;
                mode_d[c] = mode_i;
                cnt_d[c]  = '0;
                led_d[c]  = mode_i[0];
            end else if (sync && (mode_q[c] == MODE_BLINK)) begin
                cnt_d[c] = '0;
                led_d[c] = 1'b0;
            end else if (tick) begin
                case (mode_q[c])
                    MODE_BLINK: begin
                        if (cnt_q[c] == div_q[c]) begin
                            cnt_d[c] = '0;
                            led_d[c] = ~led_q[c];
                            int_d[c] = ~led_q[c];
                        end else begin
                            cnt_d[c] = cnt_q[c] + DIV_W'(1);
                        end
                    end
                    MODE_ONESHOT: begin
                        if (cnt_q[c] == div_q[c]) begin
                            cnt_d[c]  = '0;
                            led_d[c]  = 1'b0;
                            mode_d[c] = MODE_OFF;
                            int_d[c]  = 1'b1;
                        end else begin
                            cnt_d[c] = cnt_q[c] + DIV_W'(1);
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

    always_ff @(posedge clk100) begin
        if (rst) begin
            pre_q  <= '0;
            div_q  <= '{default: '0};
            cnt_q  <= '{default: '0};
            mode_q <= '{default: MODE_OFF};
            led_q  <= '0;
            int_q  <= '0;
        end else begin
            pre_q  <= pre_d;
            div_q  <= div_d;
            cnt_q  <= cnt_d;
            mode_q <= mode_d;
            led_q  <= led_d;
            int_q  <= int_d;
        end
    end

    assign led_o     = led_q;
    assign led_int_o = int_q;

endmodule

// File: tb/tb_led_cnt_multi.sv
// Directed bench for led_cnt_multi (PRESCALE=4, DIV_W=12) with a second NUM_CH=5 instance for out-of-range writes.
// The sync section is compiled only when LED_CNT_MULTI_SYNC_EN is defined.
module tb_led_cnt_multi;

    logic        clk;
    logic        rst;
    logic [11:0] div;
    logic [1:0]  mode;
    logic [1:0]  ch;
    logic        wren;
    logic [3:0]  led;
    logic [3:0]  led_int;

    logic [2:0]  ch5;
    logic        wren5;
    logic [4:0]  led5;
    logic [4:0]  led_int5;

`ifdef LED_CNT_MULTI_SYNC_EN
    logic        sync;
`endif

    int cyc;
    int n_cmp;
    int n_bad;

    led_cnt_multi #(.NUM_CH(4), .DIV_W(12), .PRESCALE(4)) u_dut (
        .clk100    (clk),
        .rst       (rst),
`ifdef LED_CNT_MULTI_SYNC_EN
        .sync_i    (sync),
`endif
        .div_i     (div),
        .mode_i    (mode),
        .ch_i      (ch),
        .wren_i    (wren),
        .led_o     (led),
        .led_int_o (led_int)
    );

    led_cnt_multi #(.NUM_CH(5), .DIV_W(12), .PRESCALE(4)) u_dut5 (
        .clk100    (clk),
        .rst       (rst),
`ifdef LED_CNT_MULTI_SYNC_EN
        .sync_i    (sync),
`endif
        .div_i     (div),
        .mode_i    (mode),
        .ch_i      (ch5),
        .wren_i    (wren5),
        .led_o     (led5),
        .led_int_o (led_int5)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic run_to(input int n);
        while (cyc < n) step();
    endtask

    task automatic do_write(input logic [1:0] c, input logic [1:0] m, input logic [11:0] d);
        ch   = c;
        mode = m;
        div  = d;
        wren = 1'b1;
        step();
        wren = 1'b0;
    endtask

    task automatic do_write5(input logic [2:0] c, input logic [1:0] m);
        ch5   = c;
        mode  = m;
        wren5 = 1'b1;
        step();
        wren5 = 1'b0;
    endtask

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        assert (got === exp) else begin
            n_bad++;
            $error("FAIL %s at cyc %0d: observed %0h expected %0h", tag, cyc, got, exp);
        end
    endtask

    initial begin
        logic [3:0] exp_led;
        logic [3:0] exp_int;
        cyc   = 0;
        n_cmp = 0;
        n_bad = 0;
        rst   = 1'b1;
        wren  = 1'b0;
        wren5 = 1'b0;
        div   = '0;
        mode  = '0;
        ch    = '0;
        ch5   = '0;
`ifdef LED_CNT_MULTI_SYNC_EN
        sync  = 1'b0;
`endif
        step();
        step();
        rst = 1'b0;
        cyc = 0;
        chk("reset_led", 32'(led), 32'h0);
        chk("reset_int", 32'(led_int), 32'h0);
        chk("reset_led5", 32'(led5), 32'h0);

        // Blink ch1 div 2: ticks land on edges 4,8,12..; toggles every 12 cycles.
        do_write(2'd1, 2'b10, 12'd2);
        chk("blink_write_led", 32'(led), 32'h0);
        while (cyc < 49) begin
            step();
            exp_led = ((cyc >= 12 && cyc < 24) || (cyc >= 36 && cyc < 48)) ? 4'b0010 : 4'b0000;
            exp_int = (cyc == 12 || cyc == 36) ? 4'b0010 : 4'b0000;
            chk("blink_led", 32'(led), 32'(exp_led));
            chk("blink_int", 32'(led_int), 32'(exp_int));
        end
        do_write(2'd1, 2'b00, 12'd0);
        chk("blink_off_led", 32'(led), 32'h0);

        // One-shot ch2 div 3 written at edge 51: completes on the fourth tick (edge 64).
        do_write(2'd2, 2'b11, 12'd3);
        chk("oneshot_start_led", 32'(led), 32'b0100);
        chk("oneshot_start_int", 32'(led_int), 32'h0);
        while (cyc < 72) begin
            step();
            exp_led = (cyc < 64) ? 4'b0100 : 4'b0000;
            exp_int = (cyc == 64) ? 4'b0100 : 4'b0000;
            chk("oneshot_led", 32'(led), 32'(exp_led));
            chk("oneshot_int", 32'(led_int), 32'(exp_int));
        end

        // Static modes and out-of-range channel writes.
        do_write(2'd0, 2'b01, 12'd0);
        chk("on_led", 32'(led), 32'b0001);
        chk("on_int", 32'(led_int), 32'h0);
        do_write(2'd0, 2'b00, 12'd0);
        chk("off_led", 32'(led), 32'h0);
        chk("off_int", 32'(led_int), 32'h0);
        do_write5(3'd5, 2'b01);
        chk("oob5_led", 32'(led5), 32'h0);
        do_write5(3'd7, 2'b01);
        chk("oob7_led", 32'(led5), 32'h0);
        do_write5(3'd4, 2'b01);
        chk("ch4_on_led", 32'(led5), 32'b10000);

        // Blink ch3 div 1 from edge 81; rewrite it on the tick at edge 88 where it would rise.
        run_to(80);
        do_write(2'd3, 2'b10, 12'd1);
        run_to(87);
        do_write(2'd3, 2'b10, 12'd1);
        chk("collide_led", 32'(led), 32'h0);
        chk("collide_int", 32'(led_int), 32'h0);
        while (cyc < 97) begin
            step();
            exp_led = (cyc >= 96) ? 4'b1000 : 4'b0000;
            exp_int = (cyc == 96) ? 4'b1000 : 4'b0000;
            chk("collide_led_after", 32'(led), 32'(exp_led));
            chk("collide_int_after", 32'(led_int), 32'(exp_int));
        end

        // All four channels blinking with div 0, then a one-cycle reset with a write attempt.
        do_write(2'd0, 2'b10, 12'd0);
        do_write(2'd1, 2'b10, 12'd0);
        do_write(2'd2, 2'b10, 12'd0);
        chk("all_blink_led_100", 32'(led), 32'b1011);
        chk("all_blink_int_100", 32'(led_int), 32'b0011);
        do_write(2'd3, 2'b10, 12'd0);
        chk("all_blink_led_101", 32'(led), 32'b0011);
        chk("all_blink_int_101", 32'(led_int), 32'h0);
        run_to(104);
        chk("all_blink_led_104", 32'(led), 32'b1100);
        chk("all_blink_int_104", 32'(led_int), 32'b1100);
        rst  = 1'b1;
        ch   = 2'd0;
        mode = 2'b01;
        wren = 1'b1;
        step();
        rst  = 1'b0;
        wren = 1'b0;
        chk("midrst_led", 32'(led), 32'h0);
        chk("midrst_int", 32'(led_int), 32'h0);
        while (cyc < 120) begin
            step();
            chk("postrst_led", 32'(led), 32'h0);
            chk("postrst_int", 32'(led_int), 32'h0);
        end

        // Ticks now fall on edges 109,113,117,121,125.
        do_write(2'd0, 2'b10, 12'd0);
        chk("rewrite_led", 32'(led), 32'h0);
        while (cyc < 125) begin
            step();
            exp_led = (cyc == 125) ? 4'b0001 : 4'b0000;
            chk("rewrite_led_after", 32'(led), 32'(exp_led));
            chk("rewrite_int_after", 32'(led_int), 32'(exp_led));
        end

`ifdef LED_CNT_MULTI_SYNC_EN
        do_write(2'd1, 2'b10, 12'd0);
        chk("sync_pre_led_126", 32'(led), 32'b0001);
        run_to(129);
        chk("sync_pre_led_129", 32'(led), 32'b0010);
        chk("sync_pre_int_129", 32'(led_int), 32'b0010);
        step();
        sync = 1'b1;
        step();
        sync = 1'b0;
        chk("sync_led", 32'(led), 32'h0);
        chk("sync_int", 32'(led_int), 32'h0);
        run_to(135);
        chk("sync_led_135", 32'(led), 32'b0011);
        chk("sync_int_135", 32'(led_int), 32'b0011);
        run_to(139);
        chk("sync_led_139", 32'(led), 32'h0);
        chk("sync_int_139", 32'(led_int), 32'h0);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/led_cnt_multi.md
LED_CNT_MULTI -- requirements
Module: led_cnt_multi

Interface
REQ-001 SHALL have parameter NUM_CH, default 4: number of LED channels, legal range 2..16.
REQ-002 SHALL have parameter DIV_W, default 12: divider register width in bits.
REQ-003 SHALL have parameter PRESCALE, default 100000: clk100 cycles per tick (1 ms at 100 MHz), minimum 2.
REQ-004 SHALL have port clk100  input  1: sole clock; all logic on its rising edge.
REQ-005 SHALL have port rst  input  1: synchronous, active-high reset.
REQ-006 SHALL have port div_i  input  DIV_W: divider value to write.
REQ-007 SHALL have port mode_i  input  2: mode to write; 00 off, 01 on, 10 blink, 11 one-shot.
REQ-008 SHALL have port ch_i  input  clog2(NUM_CH): target channel of the write.
REQ-009 SHALL have port wren_i  input  1: single-cycle write strobe.
REQ-010 SHALL have port led_o  output  NUM_CH: registered LED drive, one bit per channel.
REQ-011 SHALL have port led_int_o  output  NUM_CH: registered one-cycle event pulses, one bit per channel.

Function
REQ-012 SHALL run a free-running prescaler counting 0..PRESCALE-1 and wrapping to 0; internal tick is high for the one cycle the count equals PRESCALE-1.
REQ-013 SHALL, on wren_i with ch_i < NUM_CH, load div_i into div[ch_i], load mode_i into mode[ch_i], and clear cnt[ch_i]; the new led_o value is visible the following cycle.
REQ-014 SHALL ignore a write with ch_i >= NUM_CH: no state change.
REQ-015 SHALL set led_o[ch] on the write as follows: mode 00 gives 0, 01 gives 1, 10 gives 0, 11 gives 1.
REQ-016 SHALL hold led_o[ch] constant in modes 00 and 01; cnt[ch] does not advance.
REQ-017 SHALL, in blink mode on each tick, toggle led_o[ch] and clear cnt[ch] when cnt[ch] == div[ch], else increment cnt[ch]; period is 2*(div+1) ticks, and div=0 toggles every tick.
REQ-018 SHALL, in one-shot mode on each tick, increment cnt[ch]; when cnt[ch] == div[ch] it drives led_o[ch] to 0 and sets mode[ch] to 00, giving a high time of div+1 ticks.
REQ-019 SHALL pulse led_int_o[ch] for exactly one cycle, coincident with each 0->1 transition of led_o[ch] in blink mode and with the one-shot completion edge; no pulse on write-induced changes.
REQ-020 SHALL give a write priority when it targets a channel in the same cycle as a tick: the write is applied, the tick is lost for that channel, and no led_int_o pulse occurs.
REQ-021 SHALL update all channels independently and in parallel on the same tick.
REQ-022 SHALL never overflow cnt (width DIV_W): cnt never exceeds div in blink and one-shot modes.

Reset
REQ-023 SHALL, while rst is high at a clk100 edge, clear the prescaler, all cnt, all div, and all mode (to 00), and drive led_o and led_int_o to 0.
REQ-024 SHALL ignore wren_i in any cycle where rst is high; rst mid-blink or mid-one-shot aborts with no led_int_o pulse.
REQ-025 SHALL resume normal operation on the first cycle after rst deasserts; the first tick occurs PRESCALE cycles later.

Configuration
REQ-026 SHALL, with LED_CNT_MULTI_SYNC_EN defined, add port sync_i (input, 1 bit) and, on sync_i high, clear the prescaler and every blink-mode channel's cnt and led_o in that cycle, without a led_int_o pulse; sync_i has lower priority than rst and higher than tick, and a simultaneous write still applies to its channel.
REQ-027 SHALL, with LED_CNT_MULTI_SYNC_EN undefined, have no sync_i port; all other behaviour is unchanged.

Verification (PRESCALE=4, NUM_CH=4, DIV_W=12)
REQ-028 SHALL cover: write ch 1, mode 10, div 2, then run 48 cycles -> led_o[1] toggles every 12 cycles and led_int_o[1] pulses once per 24-cycle period, on the rising edge.
REQ-029 SHALL cover: write ch 2, mode 11, div 3 -> led_o[2]=1 for 16 cycles +/- prescaler phase, then 0 with a single led_int_o[2] pulse and mode returned to off.
REQ-030 SHALL cover: write ch 5, mode 01 -> no change on any led_o; then ch 0, mode 01, followed by ch 0, mode 00 -> led_o[0] 1 then 0 with no led_int_o.
REQ-031 SHALL cover: write to blinking ch 3 in the same cycle as a tick -> cnt[3] cleared, no toggle, no led_int_o[3] that cycle.
REQ-032 SHALL cover: rst for 1 cycle mid-blink on all 4 channels -> led_o=0000 and led_int_o=0000 the next cycle, with no pulses until a rewrite.
REQ-033 SHALL cover, with LED_CNT_MULTI_SYNC_EN: channels 0 and 1 blinking out of phase, sync_i pulse -> both led_o low, and both toggle in the same cycle thereafter.
